// File: rtl/ws2812_decoder_pkg.sv
// WS2812 shared timing constants, expressed in 50 ns sample ticks,
// plus the receive-side decoder state encoding.
package timing_constants;

    localparam int T0H_MIN_S = 4;
    localparam int T0H_MAX_S = 10;
    localparam int T1H_MIN_S = 11;
    localparam int T1H_MAX_S = 17;
    localparam int TL_MIN_S  = 4;
    localparam int TRESET_S  = 1000;

    typedef enum logic [1:0] {
        ST_WAIT_RESET,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } ws2812_dec_state_t;

endpackage

// File: rtl/ws2812_decoder_line_sampler.sv
// WS2812 line sampler: 2-flop synchronizer and a divide-by-CLK_DIV
// sample tick. The level output is the second synchronizer flop.
module ws2812_line_sampler #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic tick,
    output logic level
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] phase;
    logic          sync1;
    logic          sync2;

    // Synchronize the line and run the free-running prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            phase <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (phase == LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    assign tick  = (phase == LAST);
    assign level = sync2;

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812 receiver: measures pulse widths on sample ticks, decodes
// bits and emits 24-bit GRB pixels with a per-frame index.
module ws2812_decoder
    import timing_constants::*;
#(
    parameter int WIDTH_COUNTER = 16,
    parameter int CLK_DIV       = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    output logic [23:0]              pixel_o,
    output logic                     pixel_valid_o,
    output logic [WIDTH_COUNTER-1:0] pixel_index_o,
    output logic                     frame_end_o,
    output logic                     bit_error_o,
    output logic                     busy_o
);

    localparam int W = WIDTH_COUNTER;
    localparam logic [W-1:0] C_T0H_MIN = W'(T0H_MIN_S);
    localparam logic [W-1:0] C_T0H_MAX = W'(T0H_MAX_S);
    localparam logic [W-1:0] C_T1H_MIN = W'(T1H_MIN_S);
    localparam logic [W-1:0] C_T1H_MAX = W'(T1H_MAX_S);
    localparam logic [W-1:0] C_TL_MIN  = W'(TL_MIN_S);
    localparam logic [W-1:0] C_TRESET  = W'(TRESET_S);
    localparam logic [W-1:0] C_ONE     = W'(1);

    logic tick;
    logic level;

    ws2812_line_sampler #(
        .CLK_DIV (CLK_DIV)
    ) u_sampler (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .tick  (tick),
        .level (level)
    );

    ws2812_dec_state_t state, state_n;
    logic [W-1:0] cnt, cnt_n, cnt_inc;
    logic [W-1:0] idx, idx_n, idx_inc;
    logic [22:0]  sr, sr_n;
    logic [4:0]   bitcnt, bitcnt_n;
    logic [23:0]  pixel_n;
    logic [W-1:0] index_n;
    logic         valid_n, fe_n, be_n;
    logic         is0, is1, err;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_WAIT_RESET;
            cnt           <= '0;
            idx           <= '0;
            sr            <= '0;
            bitcnt        <= '0;
            pixel_o       <= '0;
            pixel_index_o <= '0;
            pixel_valid_o <= 1'b0;
            frame_end_o   <= 1'b0;
            bit_error_o   <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            sr            <= sr_n;
            bitcnt        <= bitcnt_n;
            pixel_o       <= pixel_n;
            pixel_index_o <= index_n;
            pixel_valid_o <= valid_n;
            frame_end_o   <= fe_n;
            bit_error_o   <= be_n;
        end
    end

    // Next-state decode; everything advances only on sample ticks.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        sr_n     = sr;
        bitcnt_n = bitcnt;
        pixel_n  = pixel_o;
        index_n  = pixel_index_o;
        valid_n  = 1'b0;
        fe_n     = 1'b0;
        be_n     = 1'b0;
        err      = 1'b0;
        cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
        idx_inc  = (&idx) ? idx : idx + 1'b1;
        is0      = (cnt >= C_T0H_MIN) && (cnt <= C_T0H_MAX);
        is1      = (cnt >= C_T1H_MIN) && (cnt <= C_T1H_MAX);
        if (tick) begin
            unique case (state)
                ST_WAIT_RESET: begin
                    if (level) begin
                        cnt_n = '0;
                    end else if (cnt_inc >= C_TRESET) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                ST_IDLE: begin
                    if (level) begin
                        state_n = ST_HIGH;
                        cnt_n   = C_ONE;
                    end
                end
                ST_HIGH: begin
                    if (level) begin
                        cnt_n = cnt_inc;
                        err   = (cnt_inc > C_T1H_MAX);
                    end else if (!(is0 || is1)) begin
                        err = 1'b1;
                    end else begin
                        sr_n = {sr[21:0], is1};
                        if (bitcnt == 5'd23) begin
                            pixel_n  = {sr, is1};
                            valid_n  = 1'b1;
                            index_n  = idx;
                            idx_n    = idx_inc;
                            bitcnt_n = '0;
                        end else begin
                            bitcnt_n = bitcnt + 1'b1;
                        end
                        state_n = ST_LOW;
                        cnt_n   = C_ONE;
                    end
                end
                ST_LOW: begin
                    if (level) begin
                        if (cnt < C_TL_MIN) begin
                            err = 1'b1;
                        end else begin
                            state_n = ST_HIGH;
                            cnt_n   = C_ONE;
                        end
                    end else if (cnt_inc >= C_TRESET) begin
                        fe_n     = 1'b1;
                        be_n     = (bitcnt != 5'd0);
                        bitcnt_n = '0;
                        idx_n    = '0;
                        state_n  = ST_IDLE;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            endcase
            if (err) begin
                be_n     = 1'b1;
                bitcnt_n = '0;
                idx_n    = '0;
                state_n  = ST_WAIT_RESET;
                cnt_n    = '0;
            end
        end
    end

    assign busy_o = (state == ST_HIGH) || (state == ST_LOW);

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed bench for ws2812_decoder: drives WS2812 waveforms with
// exact sample widths and checks decoded pixels and pulses.
module tb_ws2812_decoder;

    localparam int CLKD = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [23:0] pixel_o;
    logic        pixel_valid_o;
    logic [15:0] pixel_index_o;
    logic        frame_end_o;
    logic        bit_error_o;
    logic        busy_o;

    ws2812_decoder #(
        .WIDTH_COUNTER (16),
        .CLK_DIV       (CLKD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .din           (din),
        .pixel_o       (pixel_o),
        .pixel_valid_o (pixel_valid_o),
        .pixel_index_o (pixel_index_o),
        .frame_end_o   (frame_end_o),
        .bit_error_o   (bit_error_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    logic [23:0] pix_q[$];
    logic [15:0] idx_q[$];
    int n_fe = 0;
    int n_be = 0;
    int n_both = 0;
    int n_wide = 0;
    logic pv_d = 1'b0;
    logic fe_d = 1'b0;
    logic be_d = 1'b0;

    // Log every pulse seen on the output side.
    always @(negedge clk) begin
        if (pixel_valid_o) begin
            pix_q.push_back(pixel_o);
            idx_q.push_back(pixel_index_o);
        end
        if (frame_end_o) n_fe++;
        if (bit_error_o) n_be++;
        if (frame_end_o && bit_error_o) n_both++;
        if ((pixel_valid_o && pv_d) || (frame_end_o && fe_d) ||
            (bit_error_o && be_d)) n_wide++;
        pv_d = pixel_valid_o;
        fe_d = frame_end_o;
        be_d = bit_error_o;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] pix_at(input int i);
        if (i < pix_q.size()) return {8'h0, pix_q[i]};
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] idx_at(input int i);
        if (i < idx_q.size()) return {16'h0, idx_q[i]};
        return 32'hxxxxxxxx;
    endfunction

    task automatic hold(input int n);
        repeat (n * CLKD) @(negedge clk);
    endtask

    task automatic send_hl(input int h, input int l);
        din = 1'b1;
        hold(h);
        din = 1'b0;
        hold(l);
    endtask

    task automatic send_word(input logic [23:0] v, input int n,
                             input int lo);
        for (int i = n - 1; i >= 0; i--) begin
            send_hl(v[i] ? 14 : 7, lo);
        end
    endtask

    task automatic gap();
        din = 1'b0;
        hold(1000);
    endtask

    int bp, bf, bb, bc;

    task automatic mark();
        bp = pix_q.size();
        bf = n_fe;
        bb = n_be;
        bc = n_both;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst pixel", {8'h0, pixel_o}, 32'h0);
        chk("rst valid", {31'h0, pixel_valid_o}, 32'h0);
        chk("rst index", {16'h0, pixel_index_o}, 32'h0);
        chk("rst fe", {31'h0, frame_end_o}, 32'h0);
        chk("rst be", {31'h0, bit_error_o}, 32'h0);
        chk("rst busy", {31'h0, busy_o}, 32'h0);
        rst = 1'b0;

        gap();
        mark();
        send_word(24'hA53CF0, 24, 12);
        gap();
        chk("s1 npix", pix_q.size() - bp, 1);
        chk("s1 pix", pix_at(bp), 32'hA53CF0);
        chk("s1 idx", idx_at(bp), 0);
        chk("s1 fe", n_fe - bf, 1);
        chk("s1 be", n_be - bb, 0);

        mark();
        send_word(24'h000000, 24, 4);
        send_word(24'hFFFFFF, 24, 4);
        send_word(24'h123456, 24, 4);
        gap();
        chk("s2 npix", pix_q.size() - bp, 3);
        chk("s2 pix0", pix_at(bp), 32'h000000);
        chk("s2 pix1", pix_at(bp + 1), 32'hFFFFFF);
        chk("s2 pix2", pix_at(bp + 2), 32'h123456);
        chk("s2 idx0", idx_at(bp), 0);
        chk("s2 idx1", idx_at(bp + 1), 1);
        chk("s2 idx2", idx_at(bp + 2), 2);
        chk("s2 fe", n_fe - bf, 1);
        chk("s2 be", n_be - bb, 0);

        mark();
        send_hl(4, 4);
        send_hl(10, 4);
        send_hl(11, 4);
        send_hl(17, 4);
        send_word(24'h0ABCDE, 20, 4);
        gap();
        chk("s3 npix", pix_q.size() - bp, 1);
        chk("s3 pix", pix_at(bp), 32'h3ABCDE);
        chk("s3 idx", idx_at(bp), 0);
        chk("s3 be", n_be - bb, 0);

        mark();
        send_hl(3, 4);
        chk("h3 busy", {31'h0, busy_o}, 32'h0);
        chk("h3 be", n_be - bb, 1);
        send_word(24'h0000A5, 8, 4);
        chk("h3 busy2", {31'h0, busy_o}, 32'h0);
        gap();
        send_hl(18, 4);
        chk("h18 busy", {31'h0, busy_o}, 32'h0);
        chk("h18 be", n_be - bb, 2);
        gap();
        chk("herr npix", pix_q.size() - bp, 0);
        chk("herr fe", n_fe - bf, 0);

        mark();
        send_word(24'h000ABC, 12, 4);
        gap();
        chk("s4 npix", pix_q.size() - bp, 0);
        chk("s4 fe", n_fe - bf, 1);
        chk("s4 be", n_be - bb, 1);
        chk("s4 both", n_both - bc, 1);

        mark();
        send_word(24'h000003, 2, 4);
        send_hl(7, 3);
        send_word(24'h00005A, 8, 4);
        chk("s5 be", n_be - bb, 1);
        chk("s5 busy", {31'h0, busy_o}, 32'h0);
        chk("s5 npix0", pix_q.size() - bp, 0);
        gap();
        send_word(24'hC0FFEE, 24, 4);
        gap();
        chk("s5 npix", pix_q.size() - bp, 1);
        chk("s5 pix", pix_at(bp), 32'hC0FFEE);
        chk("s5 idx", idx_at(bp), 0);
        chk("s5 fe", n_fe - bf, 1);
        chk("s5 be2", n_be - bb, 1);

        mark();
        send_word(24'h0FFFFF, 20, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("s6 pixel", {8'h0, pixel_o}, 32'h0);
        chk("s6 valid", {31'h0, pixel_valid_o}, 32'h0);
        chk("s6 index", {16'h0, pixel_index_o}, 32'h0);
        chk("s6 fe", {31'h0, frame_end_o}, 32'h0);
        chk("s6 be", {31'h0, bit_error_o}, 32'h0);
        chk("s6 busy", {31'h0, busy_o}, 32'h0);
        rst = 1'b0;
        send_word(24'h00000F, 4, 4);
        chk("s6 npix0", pix_q.size() - bp, 0);
        gap();
        send_word(24'h0F0F0F, 24, 4);
        gap();
        chk("s6 npix", pix_q.size() - bp, 1);
        chk("s6 pix", pix_at(bp), 32'h0F0F0F);
        chk("s6 idx", idx_at(bp), 0);
        chk("s6 fecnt", n_fe - bf, 1);
        chk("s6 becnt", n_be - bb, 0);
        chk("pulse width", n_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
